// File: rtl/ex_fwd_ctrl.sv
// Execute-stage forwarding and load-use hazard controller.
// Optional build macro EX_FWD_STATS_EN adds stall_cnt / fwd_cnt statistics outputs.
module ex_fwd_ctrl #(
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_wb_en,
  input  logic              id_mem_r,
  input  logic              id_mem_w,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [1:0]        alu_1_sel,
  output logic [1:0]        alu_2_sel,
  output logic [1:0]        st_data_sel
`ifdef EX_FWD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Producer slots. The WB slot is not held: a three-back producer is already
  // visible through the register file, so MEM is the oldest slot that matters.
  logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
  logic              ex_wb_en_q, ex_wb_en_d;
  logic              ex_ld_q, ex_ld_d;
  logic [REG_AW-1:0] mem_dest_q, mem_dest_d;
  logic              mem_wb_en_q, mem_wb_en_d;

  logic              ex_valid_q, ex_valid_d;
  logic [1:0]        alu_1_sel_q, alu_1_sel_d;
  logic [1:0]        alu_2_sel_q, alu_2_sel_d;
  logic [1:0]        st_data_sel_q, st_data_sel_d;

  logic              load_use;
  logic              stall_c;
  logic              accept;
  logic [1:0]        rs_match;
  logic [1:0]        rt_match;

  // Newest producer (EX slot) wins over the older MEM slot.
  function automatic logic [1:0] fwd_match(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] e_dest,
    input logic              e_wb,
    input logic [REG_AW-1:0] m_dest,
    input logic              m_wb
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (src != ZR) begin
      if (e_wb && (e_dest == src)) begin
        sel = SEL_MEM;
      end else if (m_wb && (m_dest == src)) begin
        sel = SEL_WB;
      end
    end
    return sel;
  endfunction

  always_comb begin
    rs_match = fwd_match(id_rs, ex_dest_q, ex_wb_en_q, mem_dest_q, mem_wb_en_q);
    rt_match = fwd_match(id_rt, ex_dest_q, ex_wb_en_q, mem_dest_q, mem_wb_en_q);

    load_use = id_valid && !flush && ex_ld_q && ex_wb_en_q && (ex_dest_q != ZR) &&
               ((id_uses_rs && (ex_dest_q == id_rs)) ||
                ((id_uses_rt || id_mem_w) && (ex_dest_q == id_rt)));

    // The held instruction is never stalled twice: the load has moved to MEM.
    stall_c = (state_q == S_RUN) && load_use;
    accept  = id_valid && !stall_c && !flush;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (stall_c) state_d = S_STALL;
      S_STALL: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    mem_dest_d    = ex_dest_q;
    mem_wb_en_d   = ex_wb_en_q;
    ex_dest_d     = '0;
    ex_wb_en_d    = 1'b0;
    ex_ld_d       = 1'b0;
    ex_valid_d    = 1'b0;
    alu_1_sel_d   = SEL_RF;
    alu_2_sel_d   = SEL_RF;
    st_data_sel_d = SEL_RF;
    if (accept) begin
      ex_dest_d     = id_dest;
      ex_wb_en_d    = id_wb_en;
      ex_ld_d       = id_mem_r;
      ex_valid_d    = 1'b1;
      alu_1_sel_d   = id_uses_rs ? rs_match : SEL_RF;
      alu_2_sel_d   = id_uses_rt ? rt_match : SEL_RF;
      st_data_sel_d = id_mem_w   ? rt_match : SEL_RF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_RUN;
      ex_dest_q     <= '0;
      ex_wb_en_q    <= 1'b0;
      ex_ld_q       <= 1'b0;
      mem_dest_q    <= '0;
      mem_wb_en_q   <= 1'b0;
      ex_valid_q    <= 1'b0;
      alu_1_sel_q   <= SEL_RF;
      alu_2_sel_q   <= SEL_RF;
      st_data_sel_q <= SEL_RF;
    end else begin
      state_q       <= state_d;
      ex_dest_q     <= ex_dest_d;
      ex_wb_en_q    <= ex_wb_en_d;
      ex_ld_q       <= ex_ld_d;
      mem_dest_q    <= mem_dest_d;
      mem_wb_en_q   <= mem_wb_en_d;
      ex_valid_q    <= ex_valid_d;
      alu_1_sel_q   <= alu_1_sel_d;
      alu_2_sel_q   <= alu_2_sel_d;
      st_data_sel_q <= st_data_sel_d;
    end
  end

  assign stall       = stall_c;
  assign ex_valid    = ex_valid_q;
  assign alu_1_sel   = alu_1_sel_q;
  assign alu_2_sel   = alu_2_sel_q;
  assign st_data_sel = st_data_sel_q;

`ifdef EX_FWD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic [1:0]  fwd_inc;

  // Sels are zero on a bubble, so only accepted instructions contribute.
  always_comb begin
    fwd_inc     = {1'b0, |alu_1_sel_d} + {1'b0, |alu_2_sel_d} + {1'b0, |st_data_sel_d};
    stall_cnt_d = stall_cnt_q + {31'd0, stall_c};
    fwd_cnt_d   = fwd_cnt_q + {30'd0, fwd_inc};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// Testbench for ex_fwd_ctrl: directed vector table followed by randomized
// traffic checked against a pipeline-history reference model.
module tb_ex_fwd_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_wb_en, id_mem_r, id_mem_w, flush;
  logic       stall, ex_valid;
  logic [1:0] alu_1_sel, alu_2_sel, st_data_sel;
`ifdef EX_FWD_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  ex_fwd_ctrl #(.REG_AW(5), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dest(id_dest), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wb_en(id_wb_en), .id_mem_r(id_mem_r), .id_mem_w(id_mem_w), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .alu_1_sel(alu_1_sel),
    .alu_2_sel(alu_2_sel), .st_data_sel(st_data_sel)
`ifdef EX_FWD_STATS_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rn;
    logic       v;
    logic [4:0] rs, rt, d;
    logic       ur, ut, wb, ld, sw, fl;
    logic       cs;
    logic       es, ev;
    logic [1:0] e1, e2, ed;
  } vec_t;

  typedef struct {
    logic [4:0] dest;
    logic       wb;
    logic       ld;
  } slot_t;

  int total = 0;
  int bad   = 0;

  // Reference model: history of the producers that entered EX, newest first.
  slot_t      hist[3];
  bit         m_prev_stall = 0;
  logic       m_ev = 0;
  logic [1:0] m_s1 = 0, m_s2 = 0, m_sd = 0;
  longint     m_scnt = 0, m_fcnt = 0;

  function automatic logic [1:0] m_match(input logic [4:0] src);
    for (int age = 0; age < 2; age++) begin
      if (src != 0 && hist[age].wb && hist[age].dest == src) return 2'(age + 1);
    end
    return 2'd0;
  endfunction

  function automatic logic m_hazard(input vec_t v);
    slot_t p;
    p = hist[0];
    if (m_prev_stall || !v.v || v.fl) return 1'b0;
    if (!(p.ld && p.wb && p.dest != 0)) return 1'b0;
    return (v.ur && p.dest == v.rs) || ((v.ut || v.sw) && p.dest == v.rt);
  endfunction

  task automatic model_update(input vec_t v, input logic hz);
    slot_t nw;
    bit    acc;
    if (!v.rn) begin
      for (int i = 0; i < 3; i++) hist[i] = '{dest: 0, wb: 0, ld: 0};
      m_prev_stall = 0;
      m_ev = 0; m_s1 = 0; m_s2 = 0; m_sd = 0;
      m_scnt = 0; m_fcnt = 0;
      return;
    end
    acc  = v.v && !hz && !v.fl;
    m_ev = acc;
    m_s1 = (acc && v.ur) ? m_match(v.rs) : 2'd0;
    m_s2 = (acc && v.ut) ? m_match(v.rt) : 2'd0;
    m_sd = (acc && v.sw) ? m_match(v.rt) : 2'd0;
    m_scnt = (m_scnt + longint'(hz)) % 64'h1_0000_0000;
    m_fcnt = (m_fcnt + longint'(m_s1 != 0) + longint'(m_s2 != 0) + longint'(m_sd != 0))
             % 64'h1_0000_0000;
    nw = acc ? '{dest: v.d, wb: v.wb, ld: v.ld} : '{dest: 0, wb: 0, ld: 0};
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = nw;
    m_prev_stall = hz;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input bit from_tbl, input int idx);
    logic hz;
    @(negedge clk);
    rst = v.rn; id_valid = v.v; id_rs = v.rs; id_rt = v.rt; id_dest = v.d;
    id_uses_rs = v.ur; id_uses_rt = v.ut; id_wb_en = v.wb; id_mem_r = v.ld;
    id_mem_w = v.sw; flush = v.fl;
    #1;
    hz = m_hazard(v);
    if (v.cs) chk("stall", idx, 32'(stall), from_tbl ? 32'(v.es) : 32'(hz));
    @(posedge clk);
    model_update(v, hz);
    #1;
    chk("ex_valid", idx, 32'(ex_valid), from_tbl ? 32'(v.ev) : 32'(m_ev));
    chk("alu_1_sel", idx, 32'(alu_1_sel), from_tbl ? 32'(v.e1) : 32'(m_s1));
    chk("alu_2_sel", idx, 32'(alu_2_sel), from_tbl ? 32'(v.e2) : 32'(m_s2));
    chk("st_data_sel", idx, 32'(st_data_sel), from_tbl ? 32'(v.ed) : 32'(m_sd));
`ifdef EX_FWD_STATS_EN
    chk("stall_cnt", idx, stall_cnt, 32'(m_scnt));
    chk("fwd_cnt", idx, fwd_cnt, 32'(m_fcnt));
`endif
  endtask

  function automatic vec_t mk(
    input logic rn, v, input logic [4:0] rs, rt, d,
    input logic ur, ut, wb, ld, sw, fl, cs, es, ev,
    input logic [1:0] e1, e2, ed);
    vec_t r;
    r.rn = rn; r.v = v; r.rs = rs; r.rt = rt; r.d = d;
    r.ur = ur; r.ut = ut; r.wb = wb; r.ld = ld; r.sw = sw; r.fl = fl;
    r.cs = cs; r.es = es; r.ev = ev; r.e1 = e1; r.e2 = e2; r.ed = ed;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = '{dest: 0, wb: 0, ld: 0};
    rst = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_dest = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_wb_en = 0; id_mem_r = 0; id_mem_w = 0; flush = 0;

    //              rn v  rs  rt  d   ur ut wb ld sw fl cs es ev e1 e2 ed
    // reset with live inputs, then idle bubbles
    tbl.push_back(mk(0, 1, 3,  3,  3,  1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3,  3,  3,  1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // back-to-back ALU dependency on r3, then two-back, then three-back
    tbl.push_back(mk(1, 1, 1,  2,  3,  1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3,  4,  6,  1, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 3,  0,  8,  1, 0, 1, 0, 0, 0, 1, 0, 1, 2, 0, 0));
    tbl.push_back(mk(1, 1, 3,  0,  9,  1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    // load-use on r5 with rs==rt
    tbl.push_back(mk(1, 1, 1,  0,  5,  1, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5,  5,  10, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5,  5,  10, 1, 1, 1, 0, 0, 0, 1, 0, 1, 2, 2, 0));
    // store data from r7 with immediate operand 2
    tbl.push_back(mk(1, 1, 0,  0,  7,  1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 10, 7,  0,  1, 0, 0, 0, 1, 0, 1, 0, 1, 2, 0, 1));
    // producers of r0 are never forwarded
    tbl.push_back(mk(1, 1, 1,  1,  0,  0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1,  1,  0,  0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0,  0,  11, 1, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0));
    // two producers of r4: newest wins
    tbl.push_back(mk(1, 1, 0,  0,  4,  0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0,  0,  4,  0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 4,  4,  12, 1, 1, 1, 0, 0, 0, 1, 0, 1, 1, 1, 0));
    // flush during a load-use hazard
    tbl.push_back(mk(1, 1, 0,  0,  2,  0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2,  0,  13, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // flush while stalled squashes the held instruction
    tbl.push_back(mk(1, 1, 0,  0,  2,  0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2,  0,  13, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2,  0,  13, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2,  0,  14, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    // reset in the middle of a stall
    tbl.push_back(mk(1, 1, 0,  0,  6,  0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 6,  0,  15, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 6,  0,  15, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 6,  0,  15, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    // store-data only hazard: sw reading a just-loaded rt
    tbl.push_back(mk(1, 1, 0,  0,  9,  0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1,  9,  0,  1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1,  9,  0,  1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 2));

    foreach (tbl[i]) step(tbl[i], 1'b1, i);

    for (int n = 0; n < 600; n++) begin
      vec_t r;
      r.rn = ($urandom_range(0, 59) != 0);
      r.v  = ($urandom_range(0, 4) != 0);
      r.rs = 5'($urandom_range(0, 3));
      r.rt = 5'($urandom_range(0, 3));
      r.d  = 5'($urandom_range(0, 3));
      r.ur = 1'($urandom_range(0, 1));
      r.ut = 1'($urandom_range(0, 1));
      r.wb = ($urandom_range(0, 3) != 0);
      r.ld = ($urandom_range(0, 2) == 0);
      r.sw = ($urandom_range(0, 3) == 0);
      r.fl = ($urandom_range(0, 9) == 0);
      r.cs = 1'b1;
      r.es = 0; r.ev = 0; r.e1 = 0; r.e2 = 0; r.ed = 0;
      step(r, 1'b0, 1000 + n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
